// File: rtl/wb_pkg.sv
// rtl/wb_pkg.sv - shared types and defaults for the writeback stage
package wb_pkg;

  localparam int XLEN_DEF   = 32;
  localparam int REG_AW_DEF = 5;

  // Load funct3 encodings; anything outside this set is formatted as a word
  typedef enum logic [2:0] {
    LD_B  = 3'b000,
    LD_H  = 3'b001,
    LD_W  = 3'b010,
    LD_BU = 3'b100,
    LD_HU = 3'b101
  } ldtype_e;

  typedef struct packed {
    logic                  valid;
    logic [REG_AW_DEF-1:0] rd;
    logic [XLEN_DEF-1:0]   res;
  } wb_hist_t;

endpackage

// File: rtl/load_formatter.sv
// rtl/load_formatter.sv - extracts and extends byte/half/word load data
module load_formatter
  import wb_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
) (
  input  logic [XLEN-1:0] memres,
  input  logic [2:0]      ldtype,
  input  logic [1:0]      addr_lo,
  output logic [XLEN-1:0] result
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;
  logic [31:0] word_v;

  // Halfword pick uses addr_lo[1] only; misaligned halves never reach here
  always_comb begin
    byte_v = memres[8*addr_lo +: 8];
    half_v = addr_lo[1] ? memres[31:16] : memres[15:0];
    word_v = memres[31:0];
    case (ldtype)
      LD_B:    result = XLEN'($signed(byte_v));
      LD_BU:   result = XLEN'(byte_v);
      LD_H:    result = XLEN'($signed(half_v));
      LD_HU:   result = XLEN'(half_v);
      default: result = XLEN'($signed(word_v));
    endcase
  end

endmodule

// File: rtl/writeback_unit.sv
// rtl/writeback_unit.sv - result select, register-file write handshake and forwarding history
module writeback_unit
  import wb_pkg::*;
#(
  parameter int XLEN       = XLEN_DEF,
  parameter int HIST_DEPTH = 2,
  parameter int REG_AW     = REG_AW_DEF
) (
  input  logic                       clk,
  input  logic                       Rst_n,
  input  logic                       hold,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [REG_AW-1:0]          in_rd,
  input  logic                       in_regwrite,
  input  logic                       in_memread,
  input  logic [XLEN-1:0]            in_alures,
  input  logic [XLEN-1:0]            in_memres,
  input  logic [2:0]                 in_ldtype,
  input  logic [1:0]                 in_addr_lo,
  output logic                       rf_we,
  output logic [REG_AW-1:0]          rf_rd,
  output logic [XLEN-1:0]            rf_wdata,
  input  logic                       rf_grant,
  output logic [HIST_DEPTH-1:0]      hist_valid,
  output logic [HIST_DEPTH*REG_AW-1:0] hist_rd,
  output logic [HIST_DEPTH*XLEN-1:0] hist_res
);

  if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
    $error("writeback_unit: XLEN must be 32 or 64");
  end
  if (HIST_DEPTH < 1) begin : g_bad_depth
    $error("writeback_unit: HIST_DEPTH must be at least 1");
  end

  logic            out_valid;
  logic            out_regwrite;
  logic            we_raw;
  logic            retire;
  logic            accept;
  logic [XLEN-1:0] fmt_result;
  logic [XLEN-1:0] wb_result;

  load_formatter #(.XLEN(XLEN)) u_fmt (
    .memres  (in_memres),
    .ldtype  (in_ldtype),
    .addr_lo (in_addr_lo),
    .result  (fmt_result)
  );

  assign wb_result = in_memread ? fmt_result : in_alures;

  // x0 and non-writing entries never request the port, so they drain without a grant
  assign we_raw   = out_valid & out_regwrite & (rf_rd != '0);
  assign rf_we    = we_raw & ~hold;
  assign retire   = out_valid & ~hold & (rf_grant | ~we_raw);
  assign in_ready = ~hold & (~out_valid | retire);
  assign accept   = in_valid & in_ready;

  always_ff @(posedge clk or negedge Rst_n) begin
    if (!Rst_n) begin
      out_valid    <= 1'b0;
      out_regwrite <= 1'b0;
      rf_rd        <= '0;
      rf_wdata     <= '0;
    end else if (accept) begin
      out_valid    <= 1'b1;
      out_regwrite <= in_regwrite;
      rf_rd        <= in_rd;
      rf_wdata     <= wb_result;
    end else if (retire) begin
      out_valid    <= 1'b0;
    end
  end

  // History captures the retiring entry before the output register is overwritten
  always_ff @(posedge clk or negedge Rst_n) begin
    if (!Rst_n) begin
      hist_valid <= '0;
      hist_rd    <= '0;
      hist_res   <= '0;
    end else if (retire && we_raw) begin
      for (int i = HIST_DEPTH - 1; i > 0; i--) begin
        hist_valid[i]                <= hist_valid[i-1];
        hist_rd[i*REG_AW +: REG_AW]  <= hist_rd[(i-1)*REG_AW +: REG_AW];
        hist_res[i*XLEN +: XLEN]     <= hist_res[(i-1)*XLEN +: XLEN];
      end
      hist_valid[0]        <= 1'b1;
      hist_rd[REG_AW-1:0]  <= rf_rd;
      hist_res[XLEN-1:0]   <= rf_wdata;
    end
  end

endmodule

// File: tb/tb_writeback_unit.sv
// tb/tb_writeback_unit.sv - directed vector bench for writeback_unit
module tb_writeback_unit;

  logic        clk = 1'b0;
  logic        Rst_n;
  logic        hold;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_rd;
  logic        in_regwrite;
  logic        in_memread;
  logic [31:0] in_alures;
  logic [31:0] in_memres;
  logic [2:0]  in_ldtype;
  logic [1:0]  in_addr_lo;
  logic        rf_we;
  logic [4:0]  rf_rd;
  logic [31:0] rf_wdata;
  logic        rf_grant;
  logic [1:0]  hist_valid;
  logic [9:0]  hist_rd;
  logic [63:0] hist_res;

  int n_checks = 0;
  int n_fail   = 0;

  writeback_unit #(.XLEN(32), .HIST_DEPTH(2), .REG_AW(5)) dut (
    .clk        (clk),
    .Rst_n      (Rst_n),
    .hold       (hold),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_rd      (in_rd),
    .in_regwrite(in_regwrite),
    .in_memread (in_memread),
    .in_alures  (in_alures),
    .in_memres  (in_memres),
    .in_ldtype  (in_ldtype),
    .in_addr_lo (in_addr_lo),
    .rf_we      (rf_we),
    .rf_rd      (rf_rd),
    .rf_wdata   (rf_wdata),
    .rf_grant   (rf_grant),
    .hist_valid (hist_valid),
    .hist_rd    (hist_rd),
    .hist_res   (hist_res)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        memread;
    logic [2:0]  ldtype;
    logic [1:0]  addr_lo;
    logic [31:0] alures;
    logic [4:0]  rd;
    logic        regwrite;
    logic        exp_we;
    logic [31:0] exp_wdata;
  } vec_t;

  vec_t vecs[15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [4:0] rd, input logic rw, input logic mr,
                       input logic [2:0] lt, input logic [1:0] al, input logic [31:0] alu);
    in_valid    = 1'b1;
    in_rd       = rd;
    in_regwrite = rw;
    in_memread  = mr;
    in_ldtype   = lt;
    in_addr_lo  = al;
    in_alures   = alu;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0]  = '{1'b1, 3'b000, 2'd3, 32'h0,        5'd1,  1'b1, 1'b1, 32'hFFFFFF80};
    vecs[1]  = '{1'b1, 3'b100, 2'd1, 32'h0,        5'd2,  1'b1, 1'b1, 32'h0000007F};
    vecs[2]  = '{1'b1, 3'b001, 2'd2, 32'h0,        5'd3,  1'b1, 1'b1, 32'hFFFF80FF};
    vecs[3]  = '{1'b1, 3'b101, 2'd0, 32'h0,        5'd4,  1'b1, 1'b1, 32'h00007F01};
    vecs[4]  = '{1'b1, 3'b011, 2'd0, 32'h0,        5'd5,  1'b1, 1'b1, 32'h80FF7F01};
    vecs[5]  = '{1'b1, 3'b010, 2'd2, 32'h0,        5'd6,  1'b1, 1'b1, 32'h80FF7F01};
    vecs[6]  = '{1'b1, 3'b000, 2'd0, 32'h0,        5'd7,  1'b1, 1'b1, 32'h00000001};
    vecs[7]  = '{1'b1, 3'b000, 2'd2, 32'h0,        5'd8,  1'b1, 1'b1, 32'hFFFFFFFF};
    vecs[8]  = '{1'b1, 3'b100, 2'd3, 32'h0,        5'd9,  1'b1, 1'b1, 32'h00000080};
    vecs[9]  = '{1'b1, 3'b001, 2'd3, 32'h0,        5'd10, 1'b1, 1'b1, 32'hFFFF80FF};
    vecs[10] = '{1'b1, 3'b101, 2'd2, 32'h0,        5'd11, 1'b1, 1'b1, 32'h000080FF};
    vecs[11] = '{1'b1, 3'b111, 2'd1, 32'h0,        5'd12, 1'b1, 1'b1, 32'h80FF7F01};
    vecs[12] = '{1'b0, 3'b000, 2'd3, 32'hDEADBEEF, 5'd13, 1'b1, 1'b1, 32'hDEADBEEF};
    vecs[13] = '{1'b0, 3'b000, 2'd0, 32'h12345678, 5'd0,  1'b1, 1'b0, 32'h12345678};
    vecs[14] = '{1'b0, 3'b000, 2'd0, 32'hCAFEF00D, 5'd14, 1'b0, 1'b0, 32'hCAFEF00D};

    Rst_n = 1'b0; hold = 1'b0; in_valid = 1'b0; in_rd = '0; in_regwrite = 1'b0;
    in_memread = 1'b0; in_alures = '0; in_memres = 32'h80FF7F01; in_ldtype = '0;
    in_addr_lo = '0; rf_grant = 1'b1;
    @(negedge clk); @(negedge clk);
    chk("reset_rf_we", {31'd0, rf_we}, 32'd0);
    chk("reset_rf_rd", {27'd0, rf_rd}, 32'd0);
    chk("reset_rf_wdata", rf_wdata, 32'd0);
    chk("reset_hist_valid", {30'd0, hist_valid}, 32'd0);
    chk("reset_in_ready", {31'd0, in_ready}, 32'd1);
    Rst_n = 1'b1;

    // Table: one entry at a time, grant always available
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      drive(vecs[i].rd, vecs[i].regwrite, vecs[i].memread, vecs[i].ldtype,
            vecs[i].addr_lo, vecs[i].alures);
      @(negedge clk);
      in_valid = 1'b0;
      chk($sformatf("vec%0d_we", i), {31'd0, rf_we}, {31'd0, vecs[i].exp_we});
      chk($sformatf("vec%0d_wdata", i), rf_wdata, vecs[i].exp_wdata);
      chk($sformatf("vec%0d_rd", i), {27'd0, rf_rd}, {27'd0, vecs[i].rd});
    end
    @(negedge clk);
    @(negedge clk);

    // Streaming: 4 back-to-back ALU entries
    chk("stream_idle_we", {31'd0, rf_we}, 32'd0);
    for (int k = 0; k < 4; k++) begin
      if (k > 0) begin
        chk($sformatf("stream_we%0d", k), {31'd0, rf_we}, 32'd1);
        chk($sformatf("stream_rd%0d", k), {27'd0, rf_rd}, k);
      end
      drive(5'(k + 1), 1'b1, 1'b0, 3'b000, 2'd0, 32'((k + 1) * 16));
      chk($sformatf("stream_ready%0d", k), {31'd0, in_ready}, 32'd1);
      @(negedge clk);
    end
    chk("stream_we4", {31'd0, rf_we}, 32'd1);
    chk("stream_rd4", {27'd0, rf_rd}, 32'd4);
    in_valid = 1'b0;
    @(negedge clk);
    chk("stream_done_we", {31'd0, rf_we}, 32'd0);
    chk("stream_hist_rd0", {27'd0, hist_rd[4:0]}, 32'd4);
    chk("stream_hist_rd1", {27'd0, hist_rd[9:5]}, 32'd3);
    chk("stream_hist_res0", hist_res[31:0], 32'h40);
    chk("stream_hist_res1", hist_res[63:32], 32'h30);
    chk("stream_hist_valid", {30'd0, hist_valid}, 32'd3);

    // Backpressure: grant low for 3 cycles with a second entry waiting
    rf_grant = 1'b0;
    drive(5'd6, 1'b1, 1'b0, 3'b000, 2'd0, 32'h66);
    @(negedge clk);
    drive(5'd7, 1'b1, 1'b0, 3'b000, 2'd0, 32'h77);
    for (int c = 0; c < 3; c++) begin
      chk($sformatf("bp_ready%0d", c), {31'd0, in_ready}, 32'd0);
      chk($sformatf("bp_we%0d", c), {31'd0, rf_we}, 32'd1);
      chk($sformatf("bp_wdata%0d", c), rf_wdata, 32'h66);
      if (c < 2) @(negedge clk);
    end
    rf_grant = 1'b1;
    #1;
    chk("bp_ready_on_grant", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    chk("bp_second_rd", {27'd0, rf_rd}, 32'd7);
    chk("bp_second_wdata", rf_wdata, 32'h77);
    chk("bp_hist_rd0_a", {27'd0, hist_rd[4:0]}, 32'd6);
    chk("bp_hist_rd1_a", {27'd0, hist_rd[9:5]}, 32'd4);
    @(negedge clk);
    chk("bp_drained_we", {31'd0, rf_we}, 32'd0);
    chk("bp_hist_rd0_b", {27'd0, hist_rd[4:0]}, 32'd7);
    chk("bp_hist_res0_b", hist_res[31:0], 32'h77);
    chk("bp_hist_rd1_b", {27'd0, hist_rd[9:5]}, 32'd6);

    // x0 and non-writing entries retire without a grant and leave history alone
    rf_grant = 1'b0;
    drive(5'd0, 1'b1, 1'b0, 3'b000, 2'd0, 32'h99);
    @(negedge clk);
    drive(5'd3, 1'b0, 1'b0, 3'b000, 2'd0, 32'h33);
    chk("x0_we", {31'd0, rf_we}, 32'd0);
    chk("x0_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    chk("nowr_we", {31'd0, rf_we}, 32'd0);
    chk("nowr_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    chk("nowr_hist_rd0", {27'd0, hist_rd[4:0]}, 32'd7);
    chk("nowr_hist_res0", hist_res[31:0], 32'h77);
    chk("nowr_hist_rd1", {27'd0, hist_rd[9:5]}, 32'd6);

    // Hold for 2 cycles while an entry is pending
    rf_grant = 1'b1;
    drive(5'd9, 1'b1, 1'b0, 3'b000, 2'd0, 32'h1234);
    @(negedge clk);
    drive(5'd10, 1'b1, 1'b0, 3'b000, 2'd0, 32'h5555);
    hold = 1'b1;
    #1;
    chk("hold_we_a", {31'd0, rf_we}, 32'd0);
    chk("hold_ready_a", {31'd0, in_ready}, 32'd0);
    @(negedge clk);
    chk("hold_we_b", {31'd0, rf_we}, 32'd0);
    chk("hold_ready_b", {31'd0, in_ready}, 32'd0);
    chk("hold_wdata", rf_wdata, 32'h1234);
    chk("hold_hist_rd0", {27'd0, hist_rd[4:0]}, 32'd7);
    @(negedge clk);
    in_valid = 1'b0;
    hold = 1'b0;
    #1;
    chk("unhold_we", {31'd0, rf_we}, 32'd1);
    chk("unhold_wdata", rf_wdata, 32'h1234);
    chk("unhold_rd", {27'd0, rf_rd}, 32'd9);
    @(negedge clk);
    chk("unhold_done_we", {31'd0, rf_we}, 32'd0);
    chk("unhold_hist_rd0", {27'd0, hist_rd[4:0]}, 32'd9);
    chk("unhold_hist_res0", hist_res[31:0], 32'h1234);

    // Asynchronous reset mid-cycle with a pending write and full history
    rf_grant = 1'b0;
    drive(5'd10, 1'b1, 1'b0, 3'b000, 2'd0, 32'hAA);
    @(negedge clk);
    in_valid = 1'b0;
    chk("arst_pre_we", {31'd0, rf_we}, 32'd1);
    chk("arst_pre_hist_valid", {30'd0, hist_valid}, 32'd3);
    #2;
    Rst_n = 1'b0;
    #1;
    chk("arst_we", {31'd0, rf_we}, 32'd0);
    chk("arst_rd", {27'd0, rf_rd}, 32'd0);
    chk("arst_wdata", rf_wdata, 32'd0);
    chk("arst_hist_valid", {30'd0, hist_valid}, 32'd0);
    chk("arst_hist_rd", {22'd0, hist_rd}, 32'd0);
    chk("arst_hist_res_lo", hist_res[31:0], 32'd0);
    chk("arst_hist_res_hi", hist_res[63:32], 32'd0);
    @(negedge clk);
    Rst_n = 1'b1;
    rf_grant = 1'b1;
    drive(5'd11, 1'b1, 1'b0, 3'b000, 2'd0, 32'hBB);
    @(negedge clk);
    in_valid = 1'b0;
    chk("post_rst_we", {31'd0, rf_we}, 32'd1);
    chk("post_rst_rd", {27'd0, rf_rd}, 32'd11);
    chk("post_rst_wdata", rf_wdata, 32'hBB);
    @(negedge clk);
    chk("post_rst_hist_rd0", {27'd0, hist_rd[4:0]}, 32'd11);
    chk("post_rst_hist_valid", {30'd0, hist_valid}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule
